// File: rtl/seq_divider32.sv
// Iterative radix-2 restoring divider: signed/unsigned quotient and remainder
// after a fixed latency, with a divide-by-zero result convention.
module seq_divider32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_sign_q, op_sign_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_d, done_d, div_by_zero_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] abs_a, abs_b;

    // Register file: state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            op_sign_q   <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            mag_b_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_sign_q   <= op_sign_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            mag_b_q     <= mag_b_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= div_by_zero_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        op_sign_d     = op_sign_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        mag_b_d       = mag_b_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        quotient_d    = quotient;
        remainder_d   = remainder;
        div_by_zero_d = div_by_zero;

        abs_a = (op_sign_q && op_a_q[WIDTH-1]) ? ('0 - op_a_q) : op_a_q;
        abs_b = (op_sign_q && op_b_q[WIDTH-1]) ? ('0 - op_b_q) : op_b_q;
        trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, mag_b_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_sign_d     = sign;
                    op_a_d        = in1;
                    op_b_d        = in2;
                    div_by_zero_d = 1'b0;
                    state_d       = S_PREP;
                end
            end
            S_PREP: begin
                mag_b_d   = abs_b;
                dvd_d     = abs_a;
                rem_d     = '0;
                neg_quo_d = op_sign_q & (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
                neg_rem_d = op_sign_q & op_a_q[WIDTH-1];
                // A zero divisor still spends one RUN cycle so its latency is fixed
                count_d   = (op_b_q == '0) ? CW'(1) : CW'(WIDTH);
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
                end
                dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (mag_b_q == '0) begin
                    quotient_d    = '1;
                    remainder_d   = op_a_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d    = neg_quo_q ? ('0 - dvd_q) : dvd_q;
                    remainder_d   = neg_rem_q ? ('0 - rem_q) : rem_q;
                    div_by_zero_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_q != S_IDLE) && (state_d != S_DONE) && (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed vector table, multi-cycle
// handshake/reset sequences and randomised operands against an arithmetic model.
module tb_seq_divider32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sign        (sign),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
        int          bsy;
    } vec_t;

    vec_t vecs[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] res_q, res_r;
    logic        res_z;
    int          res_lat, res_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic, which truncates toward zero
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = 32'(sa / sb);
        r = 32'(sa % sb);
    endtask

    // One full operation; records results, latency and busy cycles
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        sign = s; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sign = ~s; in1 = $urandom; in2 = $urandom;
        res_lat  = -1;
        res_busy = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (busy) res_busy++;
            if (done) begin
                res_lat = k;
                res_q   = quotient;
                res_r   = remainder;
                res_z   = div_by_zero;
                break;
            end
        end
        if (res_lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end else begin
            @(posedge clk); #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("quotient_held", quotient, res_q);
        end
    endtask

    initial begin
        int          seen;
        logic [31:0] eq, er;
        logic        rs;
        logic [31:0] ra, rb;

        rst = 1'b0; start = 1'b0; sign = 1'b0; in1 = '0; in2 = '0;

        vecs.push_back('{1'b1, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 34, 33});
        vecs.push_back('{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 33});
        vecs.push_back('{1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 34, 33});
        vecs.push_back('{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 34, 33});
        vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34, 33});
        vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'd2,        32'h7FFFFFFF, 32'd1,        1'b0, 34, 33});
        vecs.push_back('{1'b0, 32'd5,          32'd9,        32'd0,        32'd5,        1'b0, 34, 33});
        vecs.push_back('{1'b0, 32'd50,         32'd0,        32'hFFFFFFFF, 32'd50,       1'b1, 3,  2});
        vecs.push_back('{1'b0, 32'd9,          32'd3,        32'd3,        32'd0,        1'b0, 34, 33});
        vecs.push_back('{1'b1, 32'd50,         32'd0,        32'hFFFFFFFF, 32'd50,       1'b1, 3,  2});
        vecs.push_back('{1'b1, 32'h80000000,   32'd0,        32'hFFFFFFFF, 32'h80000000, 1'b1, 3,  2});
        vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34, 33});
        vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 34, 33});

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_quotient", i), res_q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), res_r, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), 32'(res_z), 32'(vecs[i].z));
            check($sformatf("vec%0d_latency", i), 32'(res_lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(res_busy), 32'(vecs[i].bsy));
        end

        // Start pulse mid-operation must be ignored
        @(posedge clk); #1;
        sign = 1'b0; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        res_lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin start = 1'b1; sign = 1'b1; in1 = 32'd7; in2 = 32'd7; end
            if (k == 6) start = 1'b0;
            if (done) begin res_lat = k; break; end
        end
        check("midop_latency", 32'(res_lat), 32'd34);
        check("midop_quotient", quotient, 32'd333);
        check("midop_remainder", remainder, 32'd1);

        // Start presented during the done cycle must be ignored
        start = 1'b1; sign = 1'b0; in1 = 32'd8; in2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("done_cycle_start_ignored", 32'(seen), 32'd0);
        check("done_cycle_result_kept", quotient, 32'd333);

        // Asynchronous reset mid-operation abandons the operation
        @(posedge clk); #1;
        sign = 1'b0; in1 = 32'd123; in2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        run_op(1'b0, 32'd20, 32'd4);
        check("postrst_quotient", res_q, 32'd5);
        check("postrst_remainder", res_r, 32'd0);
        check("postrst_latency", 32'(res_lat), 32'd34);

        // Randomised operands against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            rs = 1'(($urandom & 32'd1));
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if (($urandom & 32'd3) == 32'd0) ra = ~ra;
            if (($urandom & 32'd3) == 32'd0) rb = ~rb;
            if (rb == 32'd0) rb = 32'd1;
            model(rs, ra, rb, eq, er);
            run_op(rs, ra, rb);
            check($sformatf("rand%0d_quotient s=%0d %h/%h", i, rs, ra, rb), res_q, eq);
            check($sformatf("rand%0d_remainder s=%0d %h/%h", i, rs, ra, rb), res_r, er);
            check($sformatf("rand%0d_dbz", i), 32'(res_z), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

endmodule
